// File: rtl/sync_down_dff_pkg.sv
// Shared constants for the down-counter slice of the counters library.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package sync_down_dff_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  // Reload register reset value for the default width.
  localparam logic [DEFAULT_WIDTH-1:0] RELOAD_RST = '1;

  // All-ones mask of w bits, right-aligned in a MAX_WIDTH vector.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_down_dff_if.sv
// Control and status bundle of the down counter.
// Latency: n/a (wires only).
// Backpressure: none; controls are sampled every clock edge.
interface sync_down_dff_if
  import sync_down_dff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;

  modport master (output en, load, load_val, auto_reload, input q, zero, tc);
  modport slave  (input en, load, load_val, auto_reload, output q, zero, tc);
endinterface

// File: rtl/sync_down_dff_down_cell.sv
// One bit of the down counter: async-reset flop, toggle-on-borrow, load/override mux.
// Latency: q updates on the rising clk edge; borrow_out is combinational.
// Backpressure: none.
module down_cell (
  input  logic clk,
  input  logic rst,
  input  logic borrow_in,     // borrow arriving at the slice below (en for bit 0)
  input  logic q_lower_zero,  // slice below currently holds 0 (tied high for bit 0)
  input  logic load,
  input  logic load_bit,
  input  logic force_sel,     // underflow edge: take force_bit instead of toggling
  input  logic force_bit,
  output logic q,
  output logic borrow_out
);

  logic borrow;

  // This bit toggles only when every lower bit is zero and counting is enabled.
  assign borrow     = borrow_in & q_lower_zero;
  assign borrow_out = borrow;

  // Bit flop: load wins over the underflow override, which wins over the toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            q <= 1'b0;
    else if (load)      q <= load_bit;
    else if (force_sel) q <= force_bit;
    else                q <= q ^ borrow;
  end

endmodule

// File: rtl/sync_down_dff.sv
// Programmable down counter / interval tick generator with reload and terminal-count pulse.
// Latency: q and tc are registered (one edge); zero is combinational from q.
// Backpressure: none; en/load act on every rising edge.
module sync_down_dff
  import sync_down_dff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  sync_down_dff_if.slave  bus
);

  localparam logic [MAX_WIDTH-1:0] ONES_FULL   = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     RELOAD_INIT = ONES_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] borrow_in;
  logic [WIDTH-1:0] lower_zero;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] force_val;
  logic             underflow;
  logic             tc;

  // Borrow chain wiring: bit 0 is fed by en, bit i by the borrow of bit i-1 and q[i-1]==0.
  assign borrow_in  = {borrow[WIDTH-2:0], bus.en};
  assign lower_zero = {~q[WIDTH-2:0], 1'b1};

  // A borrow leaving the MSB while it is zero means the whole count is 0 and enabled.
  // A simultaneous load suppresses the underflow entirely.
  assign underflow = borrow[WIDTH-1] & ~q[WIDTH-1] & ~bus.load;

  // Value taken on underflow: reload register or modulo wrap to all-ones.
  assign force_val = bus.auto_reload ? reload : RELOAD_INIT;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    down_cell u_cell (
      .clk          (clk),
      .rst          (rst),
      .borrow_in    (borrow_in[i]),
      .q_lower_zero (lower_zero[i]),
      .load         (bus.load),
      .load_bit     (bus.load_val[i]),
      .force_sel    (underflow),
      .force_bit    (force_val[i]),
      .q            (q[i]),
      .borrow_out   (borrow[i])
    );
  end

  // Reload register captures every parallel load; reset restores the all-ones interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           reload <= RELOAD_INIT;
    else if (bus.load) reload <= bus.load_val;
  end

  // Terminal-count pulse: one cycle after each underflow edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tc <= 1'b0;
    else     tc <= underflow;
  end

  assign bus.q    = q;
  assign bus.zero = (q == '0);
  assign bus.tc   = tc;

endmodule

// File: doc/sync_down_dff.md
Name: sync_down_dff

Overview:
- Parameterised synchronous down counter built from per-bit D flip-flops with a borrow chain.
- Each bit toggles when all lower bits are zero and the count is enabled.
- Adds parallel load, a reload register, an auto-reload mode, a zero flag and a registered terminal-count pulse.
- Used as a programmable interval/tick generator alongside the existing up counters in the counters library.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; decrement by one on a rising clk edge when high
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value written to q and to the reload register on load
- auto_reload  input  1  selects the action on underflow: 1 = restart from reload register, 0 = wrap to all-ones
- q  output  WIDTH  current count (registered)
- zero  output  1  combinational, high when q == 0
- tc  output  1  registered terminal-count pulse

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - q = 0, reload register = all-ones, tc = 0.
  - zero therefore reads 1 while reset is held.
  - Reset held across clock edges keeps all of these values.
- Deassertion: the first active edge after rst falls may count or load.
- Priority at each rising edge: rst > load > en > hold.
- load=1:
  - q <= load_val and reload register <= load_val.
  - tc <= 0, even if en=1 and q==0 in the same cycle (no underflow is counted).
- load=0, en=1, q != 0: q <= q - 1; tc <= 0.
- load=0, en=1, q == 0 (underflow):
  - auto_reload=1: q <= reload register.
  - auto_reload=0: q <= all-ones (modulo-2^WIDTH wrap).
  - tc <= 1 in both modes.
- load=0, en=0: q holds; tc <= 0.
- tc timing:
  - High for exactly one cycle, in the cycle after the underflow edge.
  - Continuous en with reload value R produces a tc period of R+1 cycles.
  - R = 0 with auto_reload=1: q stays 0 and tc stays high every cycle while en=1.
- auto_reload is sampled only at the underflow edge; changing it mid-count has no other effect.
- Per-bit next state:
  - borrow[0] = en.
  - borrow[i] = borrow[i-1] AND (q[i-1]==0).
  - Normal count: d[i] = q[i] XOR borrow[i].
  - The underflow case and the load mux override this.
- Reset mid-count: q clears immediately, the reload value is lost (returns to all-ones), and any pending tc is cleared.
- No combinational path from inputs to q or tc. zero depends only on q.

Decomposition:
- Shared counters package holds:
  - the default WIDTH constant;
  - a localparam for the all-ones reset value of the reload register, derived from WIDTH.
- One sub-module, down_cell: a single bit slice containing an async-reset D flop, the toggle logic and the load mux.
  - Inputs: clk, rst, borrow_in, q_lower_zero, load, load_bit, force, force_bit.
  - Outputs: q, borrow_out.
  - force is driven on the underflow edge with the reload or all-ones bit.
- Top level:
  - instantiates WIDTH down_cell slices in a generate loop;
  - holds the reload register, the underflow detect and the tc flop.

Test Plan (WIDTH=4):
- Reset then en=1, auto_reload=0 for 17 cycles → q: 0, F, E, …, 1, 0, F. tc is high only in the cycle after the 0→F edge. zero is high when q=0.
- load=1, load_val=5 for one cycle, then auto_reload=1 and en=1 continuously → q: 5,4,3,2,1,0,5,4,… with tc high once every 6 cycles, each time in the cycle where q=5 follows q=0.
- Count at q=2 with en=0 for 3 cycles → q stays 2, tc=0. Then en=1 → 1, 0.
- q=0, en=1, load=1, load_val=9 on the same edge → q=9, tc=0 next cycle, reload register=9.
- Mid-count (reload=7, q=3): assert rst between clock edges → q=0, zero=1, tc=0 immediately. After release with en=1 and auto_reload=1, the first underflow reloads F.
- load_val=0, auto_reload=1, en=1 → q stays 0 and tc is high every cycle. Toggle auto_reload to 0 → next edge q=F and tc=1, then tc=0 on the following edge.
